// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbiter and single-word sequencer in front of one spi_master
// Optional burst lock: define SPI_ARB_LOCK_EN to add the lock port.
module spi_master_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_LENGTH   = 8,
  parameter int SETTLE_CYCLES = 2,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_LENGTH-1:0]         rsp_data,
  output logic [ID_W-1:0]                grant_id,
  output logic                           ctl_busy,
  output logic                           m_start,
  output logic [DATA_LENGTH-1:0]         m_data_in,
  input  logic                           m_busy,
  input  logic [DATA_LENGTH-1:0]         m_data_out
`ifdef SPI_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]             lock
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_END,
    SETTLE,
    RESP
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  next_ptr;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic [CNT_W-1:0] settle_cnt;
  int               idx;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_start   = 1'b0;
    ctl_busy  = 1'b1;
    ack       = '0;
    case (state)
      IDLE: begin
        ctl_busy = 1'b0;
        if (win_found) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        m_start   = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (m_busy)  state_nxt = WAIT_END;
      WAIT_END:  if (!m_busy) state_nxt = SETTLE;
      SETTLE:    if (settle_cnt == '0) state_nxt = RESP;
      RESP: begin
        ack[grant_id] = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      m_data_in  <= '0;
      rsp_data   <= '0;
      settle_cnt <= '0;
    end else begin
      if (state == IDLE && win_found) begin
        grant_id  <= win_id;
        m_data_in <= req_data[int'(win_id)*DATA_LENGTH +: DATA_LENGTH];
      end
      if (state == WAIT_END && !m_busy)
        settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
      else if (state == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 1'b1;
      if (state == SETTLE && settle_cnt == '0)
        rsp_data <= m_data_out;
      // A locked winner keeps the pointer on itself so it is searched first next time.
      if (state == RESP) begin
`ifdef SPI_ARB_LOCK_EN
        rr_ptr <= lock[grant_id] ? grant_id : next_ptr;
`else
        rr_ptr <= next_ptr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - directed bench for spi_master_arbiter with a simple master model
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [7:0]  rsp_data;
  logic [1:0]  grant_id;
  logic        ctl_busy;
  logic        m_start;
  logic [7:0]  m_data_in;
  logic        m_busy;
  logic [7:0]  m_data_out;
  logic [3:0]  lock = '0;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int busy_cnt = 0;

  spi_master_arbiter #(.NUM_REQ(4), .DATA_LENGTH(8), .SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .rsp_data   (rsp_data),
    .grant_id   (grant_id),
    .ctl_busy   (ctl_busy),
    .m_start    (m_start),
    .m_data_in  (m_data_in),
    .m_busy     (m_busy),
    .m_data_out (m_data_out)
`ifdef SPI_ARB_LOCK_EN
    ,
    .lock       (lock)
`endif
  );

  always #5 clk = ~clk;

  // Master model: busy for four cycles after start, RX word is TX word xor 8'h99.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy     <= 1'b0;
      m_data_out <= '0;
      busy_cnt   <= 0;
    end else if (m_start) begin
      m_busy     <= 1'b1;
      busy_cnt   <= 3;
      m_data_out <= m_data_in ^ 8'h99;
    end else if (m_busy) begin
      if (busy_cnt == 0) m_busy <= 1'b0;
      else               busy_cnt <= busy_cnt - 1;
    end
  end

  always @(negedge clk) if (m_start) n_start++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(output logic [3:0] a, output logic [7:0] r, output logic [1:0] g);
    int n = 0;
    while (ack == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("ack_seen", 32'(ack != '0), 32'd1);
    a = ack;
    r = rsp_data;
    g = grant_id;
  endtask

  logic [3:0] a;
  logic [7:0] r;
  logic [1:0] g;
  int         s0;

  initial begin
    // Reset state
    @(negedge clk);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_rsp", rsp_data, 0);
    check_eq("rst_gid", grant_id, 0);
    check_eq("rst_busy", ctl_busy, 0);
    check_eq("rst_start", m_start, 0);
    check_eq("rst_mdin", m_data_in, 0);
    rst_n = 1'b1;

    // Single transfer: A5 out, 3C back
    @(negedge clk);
    s0       = n_start;
    req_data = {8'h13, 8'h12, 8'h11, 8'hA5};
    req      = 4'b0001;
    @(negedge clk);
    check_eq("c1_start", m_start, 1);
    check_eq("c1_mdin", m_data_in, 8'hA5);
    check_eq("c1_gid", grant_id, 0);
    check_eq("c1_busy", ctl_busy, 1);
    wait_ack(a, r, g);
    req = '0;
    check_eq("t1_ack", a, 4'b0001);
    check_eq("t1_rsp", r, 8'h3C);
    repeat (8) @(negedge clk);
    check_eq("t1_nstart", n_start - s0, 1);
    check_eq("t1_idle", ctl_busy, 0);

    // All four requesting: order 0,1,2,3,0
    do_reset();
    s0       = n_start;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, r, g);
      check_eq("rr_ack", a, 32'(1 << (k % 4)));
      check_eq("rr_gid", g, k % 4);
      check_eq("rr_rsp", r, (8'h10 + 8'(k % 4)) ^ 8'h99);
      if (k == 4) req = '0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check_eq("rr_nstart", n_start - s0, 5);

    // Wrap-around after a grant to 2
    do_reset();
    req = 4'b0100;
    wait_ack(a, r, g);
    check_eq("wr_ack2", a, 4'b0100);
    req = 4'b1010;
    @(negedge clk);
    wait_ack(a, r, g);
    check_eq("wr_ack3", a, 4'b1000);
    check_eq("wr_rsp3", r, 8'h13 ^ 8'h99);
    req = 4'b0010;
    @(negedge clk);
    wait_ack(a, r, g);
    check_eq("wr_ack1", a, 4'b0010);
    req = '0;
    @(negedge clk);

    // Requester 1 drops its request during WAIT_END
    s0  = n_start;
    req = 4'b0010;
    for (int n = 0; n < 20 && !m_busy; n++) @(negedge clk);
    @(negedge clk);
    req = '0;
    wait_ack(a, r, g);
    check_eq("drop_ack", a, 4'b0010);
    check_eq("drop_rsp", r, 8'h11 ^ 8'h99);
    repeat (8) @(negedge clk);
    check_eq("drop_nstart", n_start - s0, 1);
    check_eq("drop_idle", ctl_busy, 0);

    // Reset during WAIT_END; pointer was 2, reset must bring it to 0
    req = 4'b0001;
    for (int n = 0; n < 20 && !m_busy; n++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check_eq("mrst_busy", ctl_busy, 0);
    check_eq("mrst_gid", grant_id, 0);
    check_eq("mrst_mdin", m_data_in, 0);
    check_eq("mrst_rsp", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0101;
    @(negedge clk);
    check_eq("mrst_ptr_gid", grant_id, 0);
    check_eq("mrst_start", m_start, 1);
    wait_ack(a, r, g);
    req = 4'b0100;
    @(negedge clk);
    wait_ack(a, r, g);
    check_eq("mrst_ack2", a, 4'b0100);
    check_eq("mrst_rsp2", r, 8'h12 ^ 8'h99);
    req = '0;
    @(negedge clk);

`ifdef SPI_ARB_LOCK_EN
    // Locked requester 0 keeps winning until lock drops
    do_reset();
    lock = 4'b0001;
    req  = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      wait_ack(a, r, g);
      check_eq("lk_ack0", a, 4'b0001);
      if (k == 2) lock = '0;
      @(negedge clk);
    end
    wait_ack(a, r, g);
    check_eq("lk_ack1", a, 4'b0010);
    req = '0;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
